// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode and PC-state types for the multicycle MIPS core
package cpu_pkg;

    typedef enum logic [6:0] {
        BEQ    = 7'd30,
        BGEZ   = 7'd31,
        BGEZAL = 7'd32,
        BGTZ   = 7'd33,
        BLEZ   = 7'd34,
        BLTZ   = 7'd35,
        BLTZAL = 7'd36,
        BNE    = 7'd37,
        J      = 7'd38,
        JAL    = 7'd39,
        JALR   = 7'd40,
        JR     = 7'd41
    } internal_code_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        HALTED  = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/flag/operand bus between the control FSM and the PC unit
interface pc_unit_if;
    logic        fetch;
    logic        exec1;
    logic        exec2;
    logic        stall;
    logic [6:0]  internal_code;
    logic [15:0] offset;
    logic [25:0] instr_index;
    logic [31:0] register_data;
    logic        zero;
    logic        positive;
    logic        negative;
    logic [31:0] address;
    logic        pc_halt;
    logic        jump_pending;
    logic [31:0] link_address;
    logic        link_write;
    logic        addr_error;

    modport master (
        output fetch, exec1, exec2, stall, internal_code, offset, instr_index,
               register_data, zero, positive, negative,
        input  address, pc_halt, jump_pending, link_address, link_write, addr_error
    );

    modport slave (
        input  fetch, exec1, exec2, stall, internal_code, offset, instr_index,
               register_data, zero, positive, negative,
        output address, pc_halt, jump_pending, link_address, link_write, addr_error
    );
endinterface

// File: rtl/pc_branch_resolve.sv
// rtl/pc_branch_resolve.sv - combinational branch/jump target and take decision
module pc_branch_resolve
    import cpu_pkg::*;
#(
    parameter bit STRICT_ALIGN = 1'b1
) (
    input  logic [6:0]  code,
    input  logic [31:0] address,
    input  logic [15:0] offset,
    input  logic [25:0] instr_index,
    input  logic [31:0] register_data,
    input  logic        zero,
    input  logic        positive,
    input  logic        negative,
    output logic        take,
    output logic [31:0] target,
    output logic        is_link,
    output logic        misaligned
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        reg_jump;
    logic        cond;

    assign branch_target = address + {{14{offset[15]}}, offset, 2'b00};
    assign jump_target   = {address[31:28], instr_index, 2'b00};

    // Decode condition, target source and link behaviour per opcode
    always_comb begin
        cond     = 1'b0;
        target   = branch_target;
        reg_jump = 1'b0;
        is_link  = 1'b0;
        case (code)
            BEQ:    cond = zero;
            BNE:    cond = positive | negative;
            BGTZ:   cond = positive;
            BLEZ:   cond = zero | negative;
            BGEZ:   cond = positive | zero;
            BLTZ:   cond = negative;
            BGEZAL: begin cond = positive | zero; is_link = 1'b1; end
            BLTZAL: begin cond = negative;        is_link = 1'b1; end
            J:      begin cond = 1'b1; target = jump_target; end
            JAL:    begin cond = 1'b1; target = jump_target; is_link = 1'b1; end
            JR:     begin cond = 1'b1; target = register_data; reg_jump = 1'b1; end
            JALR:   begin cond = 1'b1; target = register_data; reg_jump = 1'b1; is_link = 1'b1; end
            default: cond = 1'b0;
        endcase
    end

    // A misaligned register jump is reported instead of being taken
    assign misaligned = STRICT_ALIGN && reg_jump && (register_data[1:0] != 2'b00);
    assign take       = cond && !misaligned;

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with delay-slot redirect, link generation and halt
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter bit          DELAY_SLOT   = 1'b1,
    parameter bit          STRICT_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    pc_unit_if.slave    bus
);

    pc_state_t   state_q, state_d;
    logic [31:0] address_q, address_d;
    logic [31:0] target_q, target_d;
    logic        jump_pending_q, jump_pending_d;
    logic        pc_halt_q, pc_halt_d;
    logic [31:0] link_address_q, link_address_d;
    logic        link_write_q, link_write_d;
    logic        addr_error_q, addr_error_d;

    logic        res_take;
    logic [31:0] res_target;
    logic        res_is_link;
    logic        res_misaligned;
    logic        unused_exec2;

    // exec2 carries no control meaning for the PC
    assign unused_exec2 = bus.exec2;

    pc_branch_resolve #(
        .STRICT_ALIGN (STRICT_ALIGN)
    ) u_resolve (
        .code          (bus.internal_code),
        .address       (address_q),
        .offset        (bus.offset),
        .instr_index   (bus.instr_index),
        .register_data (bus.register_data),
        .zero          (bus.zero),
        .positive      (bus.positive),
        .negative      (bus.negative),
        .take          (res_take),
        .target        (res_target),
        .is_link       (res_is_link),
        .misaligned    (res_misaligned)
    );

    // Next-state logic: fetch advances or consumes a redirect, exec1 resolves
    always_comb begin
        state_d        = state_q;
        address_d      = address_q;
        target_d       = target_q;
        jump_pending_d = jump_pending_q;
        pc_halt_d      = pc_halt_q;
        link_address_d = link_address_q;
        link_write_d   = 1'b0;
        addr_error_d   = 1'b0;
        if (!bus.stall && state_q != HALTED) begin
            if (bus.fetch) begin
                if (address_q == HALT_ADDR) begin
                    state_d        = HALTED;
                    pc_halt_d      = 1'b1;
                    jump_pending_d = 1'b0;
                    address_d      = HALT_ADDR;
                end else if (state_q == PENDING) begin
                    state_d        = RUN;
                    address_d      = target_q;
                    jump_pending_d = 1'b0;
                end else begin
                    address_d = address_q + PC_STEP;
                end
            end else if (bus.exec1) begin
                if (res_is_link) begin
                    link_address_d = DELAY_SLOT ? (address_q + PC_STEP) : address_q;
                    link_write_d   = 1'b1;
                end
                addr_error_d = res_misaligned;
                if (res_take && state_q == RUN) begin
                    if (DELAY_SLOT) begin
                        target_d       = res_target;
                        state_d        = PENDING;
                        jump_pending_d = 1'b1;
                    end else begin
                        address_d = res_target;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            address_q      <= RESET_VECTOR;
            target_q       <= '0;
            jump_pending_q <= 1'b0;
            pc_halt_q      <= 1'b0;
            link_address_q <= '0;
            link_write_q   <= 1'b0;
            addr_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            address_q      <= address_d;
            target_q       <= target_d;
            jump_pending_q <= jump_pending_d;
            pc_halt_q      <= pc_halt_d;
            link_address_q <= link_address_d;
            link_write_q   <= link_write_d;
            addr_error_q   <= addr_error_d;
        end
    end

    assign bus.address      = address_q;
    assign bus.pc_halt      = pc_halt_q;
    assign bus.jump_pending = jump_pending_q;
    assign bus.link_address = link_address_q;
    assign bus.link_write   = link_write_q;
    assign bus.addr_error   = addr_error_q;

endmodule
